// File: rtl/burst_ram_line_master.sv
// Turns one cache-line request into a single BurstRAM command and a BURST_COUNT-beat data phase.
// Strobe is combinational from ISSUE (no lost cycle) and is held off while mem_busy is high.
module burst_ram_line_master #(
    parameter int DEPTH_BITWIDTH = 4,
    parameter int BURST_COUNT    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [DEPTH_BITWIDTH-1:0]   req_addr,
    input  logic [BURST_COUNT*64-1:0]   req_wr_line,
    input  logic [BURST_COUNT*8-1:0]    req_mask,
    output logic [BURST_COUNT*64-1:0]   rd_line,
    output logic                        rd_line_valid,
    output logic                        done,
    output logic                        error,
    output logic                        mem_cmd,
    output logic                        mem_cmd_en,
    output logic [DEPTH_BITWIDTH-1:0]   mem_addr,
    output logic [63:0]                 mem_wr_data,
    output logic [7:0]                  mem_data_mask,
    input  logic [63:0]                 mem_rd_data,
    input  logic                        mem_rd_data_valid,
    input  logic                        mem_busy
);
    localparam int CNT_W  = (BURST_COUNT > 1) ? $clog2(BURST_COUNT) : 1;
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BURST_COUNT - 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WRITE,
        S_READ
    } state_t;

    state_t                    state_q, state_d;
    logic                      write_q, write_d;
    logic [DEPTH_BITWIDTH-1:0] addr_q, addr_d;
    logic [63:0]               wr_beats_q [BURST_COUNT];
    logic [63:0]               wr_beats_d [BURST_COUNT];
    logic [7:0]                mask_beats_q [BURST_COUNT];
    logic [7:0]                mask_beats_d [BURST_COUNT];
    logic [63:0]               rd_beats_q [BURST_COUNT];
    logic [63:0]               rd_beats_d [BURST_COUNT];
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDLE_W-1:0]         idle_q, idle_d;
    logic                      rd_line_valid_q, rd_line_valid_d;
    logic                      done_q, done_d;
    logic                      error_q, error_d;

    assign req_ready     = (state_q == S_IDLE) && !rst;
    assign mem_addr      = addr_q;
    assign rd_line_valid = rd_line_valid_q;
    assign done          = done_q;
    assign error         = error_q;

    for (genvar g = 0; g < BURST_COUNT; g++) begin : g_rd_pack
        assign rd_line[64*g +: 64] = rd_beats_q[g];
    end

    always_comb begin
        state_d         = state_q;
        write_d         = write_q;
        addr_d          = addr_q;
        wr_beats_d      = wr_beats_q;
        mask_beats_d    = mask_beats_q;
        rd_beats_d      = rd_beats_q;
        cnt_d           = cnt_q;
        idle_d          = idle_q;
        rd_line_valid_d = 1'b0;
        done_d          = 1'b0;
        error_d         = 1'b0;
        mem_cmd_en      = 1'b0;
        mem_cmd         = 1'b0;
        mem_wr_data     = '0;
        mem_data_mask   = '0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    for (int i = 0; i < BURST_COUNT; i++) begin
                        wr_beats_d[i]   = req_wr_line[64*i +: 64];
                        mask_beats_d[i] = req_mask[8*i +: 8];
                    end
                    cnt_d   = '0;
                    idle_d  = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!mem_busy) begin
                    mem_cmd_en = 1'b1;
                    mem_cmd    = write_q;
                    if (write_q) begin
                        mem_wr_data   = wr_beats_q[0];
                        mem_data_mask = mask_beats_q[0];
                        cnt_d         = CNT_W'(1);
                        state_d       = S_WRITE;
                    end else begin
                        cnt_d   = '0;
                        // The strobe cycle itself counts toward the read timeout.
                        idle_d  = IDLE_W'(1);
                        state_d = S_READ;
                    end
                end
            end
            S_WRITE: begin
                mem_wr_data   = wr_beats_q[cnt_q];
                mem_data_mask = mask_beats_q[cnt_q];
                cnt_d         = cnt_q + 1'b1;
                if (cnt_q == LAST_BEAT) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (mem_rd_data_valid) begin
                    rd_beats_d[cnt_q] = mem_rd_data;
                    cnt_d             = cnt_q + 1'b1;
                    idle_d            = IDLE_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        rd_line_valid_d = 1'b1;
                        state_d         = S_IDLE;
                    end
                end else if (idle_q == IDLE_LIMIT) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            write_q         <= 1'b0;
            addr_q          <= '0;
            cnt_q           <= '0;
            idle_q          <= '0;
            rd_line_valid_q <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            for (int i = 0; i < BURST_COUNT; i++) begin
                wr_beats_q[i]   <= '0;
                mask_beats_q[i] <= '0;
                rd_beats_q[i]   <= '0;
            end
        end else begin
            state_q         <= state_d;
            write_q         <= write_d;
            addr_q          <= addr_d;
            cnt_q           <= cnt_d;
            idle_q          <= idle_d;
            rd_line_valid_q <= rd_line_valid_d;
            done_q          <= done_d;
            error_q         <= error_d;
            wr_beats_q      <= wr_beats_d;
            mask_beats_q    <= mask_beats_d;
            rd_beats_q      <= rd_beats_d;
        end
    end

endmodule
